// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Each digit slot lasts DIV cycles: BLANK cycles with the decoder disabled to
// suppress ghosting, then DIV-BLANK cycles with the digit visible. Display
// data is double-buffered (pending/active) and swapped only at a frame
// boundary, so a frame never shows a mix of old and new nibbles.
module digit_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [1:0]  num_dig,
  input  logic        load,
  input  logic [15:0] din,
  output logic [1:0]  select,
  output logic        en,
  output logic [3:0]  digit,
  output logic        frame_done
);

  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  // Last prescaler value of a slot and of its blanking phase.
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  // With no blanking gap a slot starts directly in the visible phase.
  localparam state_t SLOT_START = (BLANK == 0) ? S_SHOW : S_BLANK;

  state_t         state_r;
  state_t         state_s;
  logic [CW-1:0]  pres_r;
  logic [CW-1:0]  pres_s;
  logic [1:0]     select_s;
  logic [1:0]     next_sel_s;
  logic [15:0]    pending_r;
  logic [15:0]    active_r;
  logic [15:0]    active_s;
  logic           frame_done_s;

  // Pick the nibble belonging to one digit index out of a 16-bit buffer.
  function automatic logic [3:0] nibble_of(input logic [15:0] data, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = data[3:0];
      2'd1:    nib = data[7:4];
      2'd2:    nib = data[11:8];
      2'd3:    nib = data[15:12];
      default: nib = 4'd0;
    endcase
    return nib;
  endfunction

  // Digit that follows the current one; wraps after the highest active digit.
  always_comb begin
    next_sel_s = 2'd0;
    if (select >= num_dig) begin
      next_sel_s = 2'd0;
    end else begin
      next_sel_s = select + 2'd1;
    end
  end

  // Next-state logic: slot timing, digit advance and the frame-boundary swap.
  always_comb begin
    state_s      = state_r;
    pres_s       = pres_r;
    select_s     = select;
    active_s     = active_r;
    frame_done_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        pres_s   = {CW{1'b0}};
        select_s = 2'd0;
        if (run) begin
          state_s  = SLOT_START;
          active_s = pending_r;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_BLANK: begin
        if (!run) begin
          state_s  = S_IDLE;
          pres_s   = {CW{1'b0}};
          select_s = 2'd0;
        end else begin
          pres_s = pres_r + CW'(1);
          if ((BLANK != 0) && (pres_r == BLANK_LAST)) begin
            state_s = S_SHOW;
          end else begin
            state_s = S_BLANK;
          end
        end
      end
      S_SHOW: begin
        if (!run) begin
          state_s  = S_IDLE;
          pres_s   = {CW{1'b0}};
          select_s = 2'd0;
        end else if (pres_r == SLOT_LAST) begin
          state_s  = SLOT_START;
          pres_s   = {CW{1'b0}};
          select_s = next_sel_s;
          if (next_sel_s == 2'd0) begin
            frame_done_s = 1'b1;
            active_s     = pending_r;
          end else begin
            frame_done_s = 1'b0;
          end
        end else begin
          pres_s = pres_r + CW'(1);
        end
      end
      default: begin
        state_s  = S_IDLE;
        pres_s   = {CW{1'b0}};
        select_s = 2'd0;
      end
    endcase
  end

  // State, buffers and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      pres_r     <= {CW{1'b0}};
      pending_r  <= 16'h0000;
      active_r   <= 16'h0000;
      select     <= 2'd0;
      en         <= 1'b0;
      digit      <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      pres_r     <= pres_s;
      active_r   <= active_s;
      select     <= select_s;
      en         <= (state_s == S_SHOW);
      digit      <= nibble_of(active_s, select_s);
      frame_done <= frame_done_s;
      if (load) begin
        pending_r <= din;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl
// Directed, table-driven bench for digit_scan_ctrl. Instance A uses DIV=8,
// BLANK=2; instance B uses DIV=8, BLANK=0 for the gapless case.
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_a, run_a, load_a;
  logic [1:0]  nd_a;
  logic [15:0] din_a;
  logic [1:0]  select_a;
  logic        en_a, fd_a;
  logic [3:0]  digit_a;

  logic        rst_b, run_b, load_b;
  logic [1:0]  nd_b;
  logic [15:0] din_b;
  logic [1:0]  select_b;
  logic        en_b, fd_b;
  logic [3:0]  digit_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          n;
    logic        rst;
    logic        run;
    logic [1:0]  nd;
    logic        load;
    logic [15:0] din;
    logic [1:0]  sel;
    logic        en;
    logic [3:0]  dig;
    logic        fd;
  } vec_t;

  vec_t vecs[$];

  digit_scan_ctrl #(.DIV(8), .BLANK(2)) dut_a (
    .clk(clk), .rst(rst_a), .run(run_a), .num_dig(nd_a), .load(load_a), .din(din_a),
    .select(select_a), .en(en_a), .digit(digit_a), .frame_done(fd_a)
  );

  digit_scan_ctrl #(.DIV(8), .BLANK(0)) dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .num_dig(nd_b), .load(load_b), .din(din_b),
    .select(select_b), .en(en_b), .digit(digit_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  function automatic void add(input int n, input logic rst, input logic run, input logic [1:0] nd,
                              input logic load, input logic [15:0] din, input logic [1:0] sel,
                              input logic en, input logic [3:0] dig, input logic fd);
    vec_t v;
    v.n = n; v.rst = rst; v.run = run; v.nd = nd; v.load = load; v.din = din;
    v.sel = sel; v.en = en; v.dig = dig; v.fd = fd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got sel/en/dig/fd=%b required %b", name, $time, act, exp);
    end
  endtask

  // One clock on instance A with the given inputs, then compare its outputs.
  task automatic step_a(input string name, input logic rst, input logic run, input logic [1:0] nd,
                        input logic load, input logic [15:0] din, input logic [1:0] sel,
                        input logic en, input logic [3:0] dig, input logic fd);
    rst_a = rst; run_a = run; nd_a = nd; load_a = load; din_a = din;
    @(posedge clk);
    #1;
    check(name, {select_a, en_a, digit_a, fd_a}, {sel, en, dig, fd});
  endtask

  task automatic step_b(input string name, input logic rst, input logic run, input logic load,
                        input logic [15:0] din, input logic [1:0] sel, input logic en,
                        input logic [3:0] dig, input logic fd);
    rst_b = rst; run_b = run; nd_b = 2'd3; load_b = load; din_b = din;
    @(posedge clk);
    #1;
    check(name, {select_b, en_b, digit_b, fd_b}, {sel, en, dig, fd});
  endtask

  initial begin
    rst_a = 1'b1; run_a = 1'b0; nd_a = 2'd3; load_a = 1'b0; din_a = 16'h0000;
    rst_b = 1'b1; run_b = 1'b0; nd_b = 2'd3; load_b = 1'b0; din_b = 16'h0000;

    // n, rst, run, nd, load, din, | sel, en, dig, fd
    add(2, 1'b1, 1'b0, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b0);
    add(1, 1'b0, 1'b0, 2'd3, 1'b1, 16'h4321, 2'd0, 1'b0, 4'h0, 1'b0);
    // Frame 1 started from IDLE: digits 1..4, no frame_done at the start.
    for (int s = 0; s < 4; s++) begin
      add(2, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'(s), 1'b0, 4'(s + 1), 1'b0);
      add(6, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'(s), 1'b1, 4'(s + 1), 1'b0);
    end
    // Frame 2: load ABCD mid-frame while select=2; old data keeps showing.
    add(1, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h1, 1'b1);
    add(1, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h1, 1'b0);
    add(6, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b1, 4'h1, 1'b0);
    add(2, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd1, 1'b0, 4'h2, 1'b0);
    add(6, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd1, 1'b1, 4'h2, 1'b0);
    add(2, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd2, 1'b0, 4'h3, 1'b0);
    add(1, 1'b0, 1'b1, 2'd3, 1'b1, 16'hABCD, 2'd2, 1'b1, 4'h3, 1'b0);
    add(5, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd2, 1'b1, 4'h3, 1'b0);
    add(2, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd3, 1'b0, 4'h4, 1'b0);
    add(6, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd3, 1'b1, 4'h4, 1'b0);
    // Frames 3 and 4 show D,C,B,A; frame 4 loads 8765 on the boundary edge.
    for (int f = 0; f < 2; f++) begin
      add(1, 1'b0, 1'b1, 2'd3, (f == 1), 16'h8765, 2'd0, 1'b0, 4'hD, 1'b1);
      add(1, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'hD, 1'b0);
      add(6, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b1, 4'hD, 1'b0);
      add(2, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd1, 1'b0, 4'hC, 1'b0);
      add(6, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd1, 1'b1, 4'hC, 1'b0);
      add(2, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd2, 1'b0, 4'hB, 1'b0);
      add(6, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd2, 1'b1, 4'hB, 1'b0);
      add(2, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd3, 1'b0, 4'hA, 1'b0);
      add(6, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd3, 1'b1, 4'hA, 1'b0);
    end
    // Frame 5 onward: 8765 active, num_dig=1 gives 16-clock frames.
    for (int f = 0; f < 2; f++) begin
      add(1, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h5, 1'b1);
      add(1, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h5, 1'b0);
      add(6, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 2'd0, 1'b1, 4'h5, 1'b0);
      add(2, 1'b0, 1'b1, 2'(1 + 2 * f), 1'b0, 16'h0000, 2'd1, 1'b0, 4'h6, 1'b0);
      add(6, 1'b0, 1'b1, 2'(1 + 2 * f), 1'b0, 16'h0000, 2'd1, 1'b1, 4'h6, 1'b0);
    end
    // num_dig raised to 3 reached select=2; now drop it to 0 mid-slot.
    add(2, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd2, 1'b0, 4'h7, 1'b0);
    add(6, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd2, 1'b1, 4'h7, 1'b0);
    for (int f = 0; f < 2; f++) begin
      add(1, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h5, 1'b1);
      add(1, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h5, 1'b0);
      add(6, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1, 4'h5, 1'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        step_a($sformatf("vec%0d.%0d", i, c), vecs[i].rst, vecs[i].run, vecs[i].nd, vecs[i].load,
               vecs[i].din, vecs[i].sel, vecs[i].en, vecs[i].dig, vecs[i].fd);
      end
    end

    // Run dropped in cycle 3 of the visible phase of a select=1 slot.
    step_a("drop_b1", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd1, 1'b0, 4'h6, 1'b0);
    step_a("drop_b2", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd1, 1'b0, 4'h6, 1'b0);
    for (int c = 0; c < 3; c++)
      step_a("drop_show", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd1, 1'b1, 4'h6, 1'b0);
    for (int c = 0; c < 3; c++)
      step_a("drop_idle", 1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h5, 1'b0);
    // Re-run: digit 0 slot starting with two blank cycles.
    step_a("rerun_b1", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h5, 1'b0);
    step_a("rerun_b2", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h5, 1'b0);
    for (int c = 0; c < 6; c++)
      step_a("rerun_show", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b1, 4'h5, 1'b0);
    for (int s = 1; s < 4; s++) begin
      for (int c = 0; c < 2; c++)
        step_a("walk_blank", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'(s), 1'b0, 4'(s + 5), 1'b0);
      for (int c = 0; c < ((s < 3) ? 6 : 1); c++)
        step_a("walk_show", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'(s), 1'b1, 4'(s + 5), 1'b0);
    end
    // Reset while select=3 and en=1, run held high throughout.
    step_a("rst_hit", 1'b1, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b0);
    step_a("rst_b1", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b0);
    step_a("rst_b2", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b0);
    step_a("rst_show", 1'b0, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b1, 4'h0, 1'b0);

    // Gapless instance: en stays high across every slot end.
    step_b("b_rst", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b0);
    step_b("b_load", 1'b0, 1'b0, 1'b1, 16'h4321, 2'd0, 1'b0, 4'h0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      logic [1:0] s;
      s = 2'(((k - 1) / 8) % 4);
      step_b($sformatf("b_run%0d", k), 1'b0, 1'b1, 1'b0, 16'h0000, s, 1'b1, 4'(s) + 4'd1,
             (k > 1) && (((k - 1) % 32) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
